// File: rtl/promotion_overlay_ctrl_pkg.sv
// Shared types and constants for the pawn-promotion overlay.
package promo_pkg;

    typedef enum logic [1:0] {P_IDLE, P_SHOW, P_CONFIRM} promo_state_t;
    typedef enum logic [1:0] {PC_Q, PC_R, PC_B, PC_N} promo_piece_t;

    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_ENTER = 8'h28;

    localparam int unsigned PROMO_TILES = 4;

endpackage

// File: rtl/promotion_overlay_ctrl_if.sv
// Bus between the promotion overlay and the game FSM, keyboard decoder,
// sprite ROM and palette lookup. slave = overlay side, master = environment.
interface promotion_overlay_ctrl_if;
    logic        promo_req;
    logic        promo_side;
    logic        key_valid;
    logic [7:0]  keycode;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic [3:0]  rom_index;
    logic [13:0] rom_addr;
    logic        rom_side;
    logic [3:0]  pix_index;
    logic        pix_valid;
    logic        busy;
    logic [1:0]  piece_sel;
    logic        done;

    modport slave (
        input  promo_req, promo_side, key_valid, keycode, DrawX, DrawY, rom_index,
        output rom_addr, rom_side, pix_index, pix_valid, busy, piece_sel, done
    );

    modport master (
        output promo_req, promo_side, key_valid, keycode, DrawX, DrawY, rom_index,
        input  rom_addr, rom_side, pix_index, pix_valid, busy, piece_sel, done
    );
endinterface

// File: rtl/promotion_overlay_ctrl_addr_gen.sv
// First pixel stage of the overlay: window test, tile decode, sprite-ROM
// address and highlight-border flags, all registered.
module promo_addr_gen
    import promo_pkg::*;
#(
    parameter int unsigned ORIGIN_X = 224,
    parameter int unsigned ORIGIN_Y = 208,
    parameter int unsigned TILE     = 48
)(
    input  logic         Clk,
    input  logic         Reset,
    input  logic         show,
    input  promo_piece_t cursor,
    input  logic [9:0]   DrawX,
    input  logic [9:0]   DrawY,
    output logic [13:0]  rom_addr,
    output logic         in_win,
    output logic         sel,
    output logic         border
);

    localparam logic [9:0]  X_LO    = 10'(ORIGIN_X);
    localparam logic [9:0]  X_HI    = 10'(ORIGIN_X + PROMO_TILES * TILE);
    localparam logic [9:0]  Y_LO    = 10'(ORIGIN_Y);
    localparam logic [9:0]  Y_HI    = 10'(ORIGIN_Y + TILE);
    localparam logic [9:0]  T1      = 10'(TILE);
    localparam logic [9:0]  T2      = 10'(2 * TILE);
    localparam logic [9:0]  T3      = 10'(3 * TILE);
    localparam logic [9:0]  B_LO    = 10'd2;
    localparam logic [9:0]  B_HI    = 10'(TILE - 2);
    localparam logic [13:0] TILE_W  = 14'(TILE);
    localparam logic [13:0] TILE_SQ = 14'(TILE * TILE);

    logic        win_c;
    logic        edge_c;
    logic [9:0]  rx;
    logic [9:0]  tx;
    logic [9:0]  ty;
    logic [9:0]  tile_base;
    logic [1:0]  tile;
    logic [13:0] addr_c;

    // Window test and tile decode; tile index by comparing against multiples of TILE
    always_comb begin
        win_c = show && (DrawX >= X_LO) && (DrawX < X_HI) && (DrawY >= Y_LO) && (DrawY < Y_HI);
        rx    = DrawX - X_LO;
        ty    = DrawY - Y_LO;
        if (rx >= T3) begin
            tile      = 2'd3;
            tile_base = T3;
        end else if (rx >= T2) begin
            tile      = 2'd2;
            tile_base = T2;
        end else if (rx >= T1) begin
            tile      = 2'd1;
            tile_base = T1;
        end else begin
            tile      = 2'd0;
            tile_base = '0;
        end
        tx     = rx - tile_base;
        addr_c = 14'(tile) * TILE_SQ + 14'(ty) * TILE_W + 14'(tx);
        edge_c = (tx < B_LO) || (tx >= B_HI) || (ty < B_LO) || (ty >= B_HI);
    end

    // S0 registers; address forced to 0 outside the window
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr <= '0;
            in_win   <= 1'b0;
            sel      <= 1'b0;
            border   <= 1'b0;
        end else begin
            rom_addr <= win_c ? addr_c : '0;
            in_win   <= win_c;
            sel      <= win_c && (tile == 2'(cursor));
            border   <= win_c && edge_c;
        end
    end

endmodule

// File: rtl/promotion_overlay_ctrl.sv
// Pawn-promotion overlay controller: menu FSM, cursor, piece commit and the
// second pixel stage. Optional auto-confirm timeout under PROMO_TIMEOUT_EN.
module promotion_overlay_ctrl
    import promo_pkg::*;
#(
    parameter int unsigned ORIGIN_X   = 224,
    parameter int unsigned ORIGIN_Y   = 208,
    parameter int unsigned TILE       = 48,
    parameter logic [3:0]  HILITE_IDX = 4'd1
`ifdef PROMO_TIMEOUT_EN
    , parameter int unsigned TIMEOUT_CYC = 500000
`endif
)(
    input logic                    Clk,
    input logic                    Reset,
    promotion_overlay_ctrl_if.slave bus
);

    promo_state_t state, state_n;
    promo_piece_t cursor, cursor_n;

    logic        key_left, key_right, key_enter;
    logic        timeout;
    logic        done_q;
    logic        rom_side_q;
    logic [1:0]  piece_sel_q;
    logic        pix_valid_q;
    logic [3:0]  pix_index_q;
    logic [13:0] s0_addr;
    logic        s0_win, s0_sel, s0_border;

    assign key_left  = bus.key_valid && (bus.keycode == KEY_LEFT);
    assign key_right = bus.key_valid && (bus.keycode == KEY_RIGHT);
    assign key_enter = bus.key_valid && (bus.keycode == KEY_ENTER);

`ifdef PROMO_TIMEOUT_EN
    localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TO_W-1:0] to_cnt;

    assign timeout = (state == P_SHOW) && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    // Idle counter: runs only in SHOW, restarts on any key press
    always_ff @(posedge Clk) begin
        if (Reset) begin
            to_cnt <= '0;
        end else if ((state != P_SHOW) || bus.key_valid || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // State and cursor registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state  <= P_IDLE;
            cursor <= PC_Q;
        end else begin
            state  <= state_n;
            cursor <= cursor_n;
        end
    end

    // Next state and cursor; ENTER outranks the timeout, which outranks arrows
    always_comb begin
        state_n  = state;
        cursor_n = cursor;
        case (state)
            P_IDLE: begin
                if (bus.promo_req) begin
                    state_n  = P_SHOW;
                    cursor_n = PC_Q;
                end
            end
            P_SHOW: begin
                if (key_enter) begin
                    state_n = P_CONFIRM;
                end else if (timeout) begin
                    state_n  = P_CONFIRM;
                    cursor_n = PC_Q;
                end else if (key_left) begin
                    cursor_n = promo_piece_t'(2'(cursor) - 2'd1);
                end else if (key_right) begin
                    cursor_n = promo_piece_t'(2'(cursor) + 2'd1);
                end
            end
            P_CONFIRM: state_n = P_IDLE;
            default:   state_n = P_IDLE;
        endcase
    end

    // Side latch on menu open, piece commit and done pulse
    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_side_q  <= 1'b0;
            piece_sel_q <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state == P_CONFIRM);
            if (state == P_CONFIRM) begin
                piece_sel_q <= 2'(cursor);
            end
            if ((state == P_IDLE) && bus.promo_req) begin
                rom_side_q <= bus.promo_side;
            end
        end
    end

    promo_addr_gen #(
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y),
        .TILE     (TILE)
    ) u_addr_gen (
        .Clk      (Clk),
        .Reset    (Reset),
        .show     (state == P_SHOW),
        .cursor   (cursor),
        .DrawX    (bus.DrawX),
        .DrawY    (bus.DrawY),
        .rom_addr (s0_addr),
        .in_win   (s0_win),
        .sel      (s0_sel),
        .border   (s0_border)
    );

    // S1: ROM data or highlight colour, zeroed when the overlay does not own the pixel
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pix_valid_q <= 1'b0;
            pix_index_q <= '0;
        end else begin
            pix_valid_q <= s0_win;
            if (!s0_win) begin
                pix_index_q <= '0;
            end else if (s0_sel && s0_border) begin
                pix_index_q <= HILITE_IDX;
            end else begin
                pix_index_q <= bus.rom_index;
            end
        end
    end

    assign bus.rom_addr  = s0_addr;
    assign bus.rom_side  = rom_side_q;
    assign bus.pix_index = pix_index_q;
    assign bus.pix_valid = pix_valid_q;
    assign bus.busy      = (state != P_IDLE);
    assign bus.piece_sel = piece_sel_q;
    assign bus.done      = done_q;

endmodule

// File: tb/tb_promotion_overlay_ctrl.sv
// Self-checking bench for promotion_overlay_ctrl: directed scenarios plus
// randomized traffic compared cycle by cycle against a behavioural model.
module tb_promotion_overlay_ctrl;

    localparam int OX = 224;
    localparam int OY = 208;
    localparam int T  = 48;
    localparam int HL = 1;
`ifdef PROMO_TIMEOUT_EN
    localparam int TO = 20;
`endif

    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic rom_force = 1'b0;
    int   checks = 0;
    int   errors = 0;

    promotion_overlay_ctrl_if bus();

    promotion_overlay_ctrl #(
        .ORIGIN_X   (OX),
        .ORIGIN_Y   (OY),
        .TILE       (T),
        .HILITE_IDX (4'(HL))
`ifdef PROMO_TIMEOUT_EN
        , .TIMEOUT_CYC (TO)
`endif
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [3:0] rom_hash(input logic [13:0] a);
        return a[3:0] ^ a[7:4] ^ a[11:8] ^ {2'b00, a[13:12]};
    endfunction

    assign bus.rom_index = rom_force ? 4'h7 : rom_hash(bus.rom_addr);

    // Behavioural model state
    bit m_open, m_commit, m_side, m_done;
    int m_cursor, m_piece, m_cnt;
    bit m_win, m_hl;
    int m_addr;
    bit e_pv;
    int e_pi;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit req, input bit side, input bit kv,
                              input logic [7:0] kc, input int x, input int y);
        bit win, hl, enter, fire;
        int rx, tile, tx, ty, addr;
        if (rst) begin
            m_open = 0; m_commit = 0; m_side = 0; m_done = 0;
            m_cursor = 0; m_piece = 0; m_cnt = 0;
            m_win = 0; m_hl = 0; m_addr = 0; e_pv = 0; e_pi = 0;
            return;
        end
        e_pv = m_win;
        e_pi = !m_win ? 0 : m_hl ? HL : (rom_force ? 7 : int'(rom_hash(14'(m_addr))));
        win  = m_open && x >= OX && x < OX + 4 * T && y >= OY && y < OY + T;
        hl   = 0;
        addr = 0;
        if (win) begin
            rx   = x - OX;
            tile = rx / T;
            tx   = rx % T;
            ty   = y - OY;
            addr = tile * T * T + ty * T + tx;
            hl   = (tile == m_cursor) && (tx < 2 || tx >= T - 2 || ty < 2 || ty >= T - 2);
        end
        m_win = win; m_hl = hl; m_addr = addr;
        m_done = m_commit;
        if (m_commit) begin
            m_piece  = m_cursor;
            m_commit = 0;
        end else if (m_open) begin
            enter = kv && kc == 8'h28;
            fire  = 0;
`ifdef PROMO_TIMEOUT_EN
            fire  = (m_cnt == TO - 1);
`endif
            if (enter) begin
                m_open = 0; m_commit = 1;
            end else if (fire) begin
                m_cursor = 0; m_open = 0; m_commit = 1;
            end else if (kv && kc == 8'h50) begin
                m_cursor = (m_cursor + 3) % 4;
            end else if (kv && kc == 8'h4F) begin
                m_cursor = (m_cursor + 1) % 4;
            end
            m_cnt = (kv || fire) ? 0 : m_cnt + 1;
        end else if (req) begin
            m_open = 1; m_cursor = 0; m_side = side; m_cnt = 0;
        end
    endtask

    task automatic compare_all();
        check("busy",      32'(bus.busy),      32'(m_open | m_commit));
        check("done",      32'(bus.done),      32'(m_done));
        check("piece_sel", 32'(bus.piece_sel), 32'(m_piece));
        check("rom_side",  32'(bus.rom_side),  32'(m_side));
        check("rom_addr",  32'(bus.rom_addr),  32'(m_addr));
        check("pix_valid", 32'(bus.pix_valid), 32'(e_pv));
        check("pix_index", 32'(bus.pix_index), 32'(e_pi));
    endtask

    task automatic tick(input bit rst, input bit req, input bit side, input bit kv,
                        input logic [7:0] kc, input int x, input int y);
        Reset          = rst;
        bus.promo_req  = req;
        bus.promo_side = side;
        bus.key_valid  = kv;
        bus.keycode    = kc;
        bus.DrawX      = 10'(x);
        bus.DrawY      = 10'(y);
        model_step(rst, req, side, kv, kc, x, y);
        @(negedge Clk);
        compare_all();
    endtask

    task automatic idle(input int x, input int y);
        tick(0, 0, 0, 0, 8'h00, x, y);
    endtask

    task automatic key(input logic [7:0] kc);
        tick(0, 0, 0, 1, kc, 0, 0);
    endtask

    initial begin
        bus.promo_req = 0; bus.promo_side = 0; bus.key_valid = 0;
        bus.keycode = '0; bus.DrawX = '0; bus.DrawY = '0;
        @(negedge Clk);
        repeat (3) tick(1, 0, 0, 0, 8'h00, 0, 0);
        check("rst_busy", 32'(bus.busy), 0);

        // Open with black side; key in the same cycle is ignored
        tick(0, 1, 1, 1, 8'h4F, 0, 0);
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_side", 32'(bus.rom_side), 1);
        check("t1_done", 32'(bus.done), 0);

        // RIGHT x5 wraps to rook; done two cycles after ENTER
        repeat (5) key(8'h4F);
        key(8'h11);
        key(8'h28);
        check("t2_done_early", 32'(bus.done), 0);
        idle(0, 0);
        check("t2_done", 32'(bus.done), 1);
        check("t2_busy", 32'(bus.busy), 0);
        check("t2_piece", 32'(bus.piece_sel), 1);
        idle(0, 0);
        check("t2_done_once", 32'(bus.done), 0);

        // LEFT from queen wraps to knight
        tick(0, 1, 0, 0, 8'h00, 0, 0);
        key(8'h50);
        key(8'h28);
        idle(0, 0);
        check("t3_piece", 32'(bus.piece_sel), 3);

        // Pixel path with cursor on tile 2
        tick(0, 1, 1, 0, 8'h00, 0, 0);
        key(8'h4F);
        key(8'h4F);
        rom_force = 1;
        idle(330, 230);
        check("t4_addr", 32'(bus.rom_addr), 5674);
        idle(320, 230);
        check("t4_pv", 32'(bus.pix_valid), 1);
        check("t4_pi", 32'(bus.pix_index), 7);
        idle(223, 230);
        check("t4_hilite", 32'(bus.pix_index), HL);
        idle(330, 256);
        check("t5_x_edge_pv", 32'(bus.pix_valid), 0);
        idle(0, 0);
        check("t5_y_edge_pv", 32'(bus.pix_valid), 0);
        check("t5_y_edge_pi", 32'(bus.pix_index), 0);
        rom_force = 0;
        key(8'h28);
        idle(330, 230);
        idle(330, 230);
        idle(0, 0);
        check("t5_idle_pv", 32'(bus.pix_valid), 0);

        // Reset mid-menu and promo_req while busy
        tick(0, 1, 1, 0, 8'h00, 0, 0);
        tick(0, 1, 0, 0, 8'h00, 0, 0);
        check("t6_side_hold", 32'(bus.rom_side), 1);
        key(8'h4F);
        tick(1, 0, 0, 0, 8'h00, 0, 0);
        check("t6_rst_busy", 32'(bus.busy), 0);
        check("t6_rst_piece", 32'(bus.piece_sel), 0);
        idle(0, 0);
        check("t6_rst_done", 32'(bus.done), 0);

`ifdef PROMO_TIMEOUT_EN
        begin
            bit seen;
            seen = 0;
            tick(0, 1, 0, 0, 8'h00, 0, 0);
            key(8'h4F);
            for (int i = 0; i < 40 && !seen; i++) begin
                idle(0, 0);
                seen = bus.done;
            end
            check("t6_timeout_done", 32'(seen), 1);
            check("t6_timeout_piece", 32'(bus.piece_sel), 0);
        end
`endif

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit r_rst, r_req, r_kv;
            logic [7:0] r_kc;
            int sel;
            r_rst = ($urandom % 300) == 0;
            r_req = ($urandom % 6) == 0;
            r_kv  = ($urandom % 4) == 0;
            sel   = int'($urandom % 8);
            r_kc  = (sel < 3) ? 8'h50 : (sel < 6) ? 8'h4F : (sel == 6) ? 8'h28 : 8'($urandom);
            tick(r_rst, r_req, 1'($urandom), r_kv, r_kc,
                 int'($urandom_range(200, 440)), int'($urandom_range(190, 270)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
